// File: rtl/qcv_lsu.sv
// Load/store unit for the qcv core: runs one access at a time on the req/gnt/rvalid data bus.
// Misaligned accesses are split into two word-aligned beats, and load data is aligned and extended.
module qcv_lsu (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_busy_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o,
  output logic        lsu_rf_we_o,
  output logic [31:0] lsu_rdata_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ1  = 3'd1,
    S_RESP1 = 3'd2,
    S_REQ2  = 3'd3,
    S_RESP2 = 3'd4
  } state_e;

  state_e      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_beat1;
  logic [1:0]  r_type;
  logic        r_we;
  logic        r_sext;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic        r_rf_we;
  logic [31:0] r_rdata;

  logic [1:0]  w_off;
  logic [3:0]  w_base_be;
  logic [7:0]  w_be8;
  logic [63:0] w_wd64;
  logic        w_split;
  logic [31:0] w_word_addr;
  logic [31:0] w_lo;
  logic [31:0] w_hi;
  logic [31:0] w_r32;
  logic [31:0] w_load;
  logic        w_last_beat;

  assign w_off       = r_addr[1:0];
  assign w_word_addr = {r_addr[31:2], 2'b00};

  always_comb begin
    case (r_type)
      2'b00:   w_base_be = 4'b0001;
      2'b01:   w_base_be = 4'b0011;
      default: w_base_be = 4'b1111;
    endcase
  end

  assign w_be8   = {4'b0000, w_base_be} << w_off;
  assign w_wd64  = {32'b0, r_wdata} << {w_off, 3'b000};
  assign w_split = |w_be8[7:4];

  // The final beat's data is still on the bus at the completing edge, so assemble from it directly.
  assign w_lo  = (r_state == S_RESP1) ? data_rdata_i : r_beat1;
  assign w_hi  = (r_state == S_RESP2) ? data_rdata_i : 32'b0;
  assign w_r32 = 32'({w_hi, w_lo} >> {w_off, 3'b000});

  always_comb begin
    case (r_type)
      2'b00:   w_load = {{24{r_sext & w_r32[7]}}, w_r32[7:0]};
      2'b01:   w_load = {{16{r_sext & w_r32[15]}}, w_r32[15:0]};
      default: w_load = w_r32;
    endcase
  end

  assign w_last_beat = data_rvalid_i &&
                       ((r_state == S_RESP2) ||
                        ((r_state == S_RESP1) && (data_err_i || !w_split)));

  always_comb begin
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_be_o    = 4'b0000;
    data_addr_o  = 32'b0;
    data_wdata_o = 32'b0;
    if (r_state == S_REQ1) begin
      data_req_o   = 1'b1;
      data_we_o    = r_we;
      data_be_o    = w_be8[3:0];
      data_addr_o  = w_word_addr;
      data_wdata_o = w_wd64[31:0];
    end else if (r_state == S_REQ2) begin
      data_req_o   = 1'b1;
      data_we_o    = r_we;
      data_be_o    = w_be8[7:4];
      data_addr_o  = w_word_addr + 32'd4;
      data_wdata_o = w_wd64[63:32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_addr       <= 32'b0;
      r_wdata      <= 32'b0;
      r_beat1      <= 32'b0;
      r_type       <= 2'b00;
      r_we         <= 1'b0;
      r_sext       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rf_we      <= 1'b0;
      r_rdata      <= 32'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rf_we      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (lsu_req_i) begin
            r_addr  <= lsu_addr_i;
            r_wdata <= lsu_wdata_i;
            r_type  <= lsu_type_i;
            r_we    <= lsu_we_i;
            r_sext  <= lsu_sign_ext_i;
            r_state <= S_REQ1;
          end
        end
        S_REQ1:  if (data_gnt_i) r_state <= S_RESP1;
        S_RESP1: begin
          if (data_rvalid_i) begin
            r_beat1 <= data_rdata_i;
            // A first-beat error completes the access without issuing the second beat.
            r_state <= (data_err_i || !w_split) ? S_IDLE : S_REQ2;
          end
        end
        S_REQ2:  if (data_gnt_i) r_state <= S_RESP2;
        S_RESP2: if (data_rvalid_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_last_beat) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= data_err_i;
        r_rf_we      <= !r_we && !data_err_i;
        r_rdata      <= w_load;
      end
    end
  end

  assign lsu_busy_o       = (r_state != S_IDLE);
  assign lsu_resp_valid_o = r_resp_valid;
  assign lsu_resp_err_o   = r_resp_err;
  assign lsu_rf_we_o      = r_rf_we;
  assign lsu_rdata_o      = r_rdata;

endmodule
